// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The HALT state exists only when FETCH_MISALIGN_TRAP_EN is defined.
package fetch_pkg;

  localparam int          BUF_DEPTH        = 2;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
`ifdef FETCH_MISALIGN_TRAP_EN
    IDLE,
    REQ,
    DRAIN,
    HALT
`else
    IDLE,
    REQ,
    DRAIN
`endif
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction buffer between fetch and decode.
// Flush empties it synchronously and wins over push/pop in the same cycle.
// Push and pop may coincide even when full; the head is read combinationally.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = fetch_pkg::BUF_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t mem [DEPTH];
  logic   wr_ptr;
  logic   rd_ptr;
  logic   push_ok;
  logic   pop_ok;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push_ok) - 2'(pop_ok);
    end
  end

  // Entry storage needs no reset; contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues word fetches to imem, buffers up to two
// instructions for decode, and handles redirects from execute.
// Optional macro FETCH_MISALIGN_TRAP_EN turns misaligned redirect targets
// into a sticky halt instead of silently clearing the low address bits.
//
// state | meaning
// IDLE  | buffer full (or about to be), no request on imem
// REQ   | fetching at fetch_pc, one request per cycle while there is room
// DRAIN | redirect arrived mid-request; waiting for the stale ack to discard it
// HALT  | misaligned redirect seen; finish any outstanding request, then stop
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = fetch_pkg::DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = fetch_pkg::BUF_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  import fetch_pkg::*;

  state_e      state;
  state_e      state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] hold_addr;
  logic [31:0] redir_target;
  logic        redir;
  logic        misalign;
  logic        push;
  logic        pop;
  logic [1:0]  count;
  logic [1:0]  count_nxt;
  entry_t      head;
  entry_t      push_data;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        halt_pend;

  // Once halted, execute can no longer steer fetch.
  assign redir        = redirect_valid && (state != HALT);
  assign misalign     = redir && (redirect_pc[1:0] != 2'b00);
  assign redir_target = redirect_pc;
`else
  assign redir        = redirect_valid;
  assign misalign     = 1'b0;
  assign redir_target = redirect_pc & 32'hFFFF_FFFC;
`endif

  // A redirect kills both the incoming word and the consumer's pop.
  assign push      = (state == REQ) && imem_ack && !redir;
  assign pop       = instr_valid && instr_ready && !redir;
  assign count_nxt = count + 2'(push) - 2'(pop);
  assign push_data = '{pc: fetch_pc, instr: imem_rdata};

  // While a stale request is outstanding the bus must keep its address.
  assign imem_addr = ((state == IDLE) || (state == REQ)) ? fetch_pc : hold_addr;

  // Next-state and request decode.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      IDLE: begin
        if (redir) begin
          state_nxt = REQ;
        end else if (count_nxt < 2'd2) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (redir) begin
          state_nxt = imem_ack ? REQ : DRAIN;
        end else if (imem_ack && (count_nxt == 2'd2)) begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (redir) begin
          state_nxt = imem_ack ? REQ : DRAIN;
        end else if (imem_ack) begin
          state_nxt = REQ;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      HALT: begin
        imem_req = halt_pend;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    if (misalign) state_nxt = HALT;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch PC: redirect target has priority over sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redir) begin
      fetch_pc <= redir_target;
    end else if (push) begin
      fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  // Remember the address of a request that is abandoned by a redirect.
  always_ff @(posedge clk) begin
    if (redir && (state == REQ)) hold_addr <= fetch_pc;
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Track an outstanding request into HALT and the sticky trap flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_pend      <= 1'b0;
      fetch_misalign <= 1'b0;
    end else begin
      if (misalign) begin
        halt_pend      <= ((state == REQ) || (state == DRAIN)) && !imem_ack;
        fetch_misalign <= 1'b1;
      end else if ((state == HALT) && imem_ack) begin
        halt_pend <= 1'b0;
      end
    end
  end
`endif

  fetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (redir),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  assign instr_valid = (count != 2'd0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model returns addr ^ MAGIC,
// expected buffer entries are queued as acks are driven and compared as
// decode consumes them. A second instance checks PC wrap from a high RESET_PC.
module tb_instr_fetch;

  localparam logic [31:0] MAGIC = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        rst2;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_misalign;

  logic        d2_req;
  logic [31:0] d2_addr;
  logic [31:0] d2_rdata;
  logic        d2_valid;
  logic [31:0] d2_instr;
  logic [31:0] d2_pc;
  logic        d2_misalign;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  assign imem_rdata = imem_addr ^ MAGIC;
  assign d2_rdata   = d2_addr ^ MAGIC;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  instr_fetch #(
    .RESET_PC (32'hFFFF_FFF8),
    .BUF_DEPTH(2)
  ) dut2 (
    .clk           (clk),
    .rst           (rst2),
    .imem_req      (d2_req),
    .imem_addr     (d2_addr),
    .imem_ack      (1'b1),
    .imem_rdata    (d2_rdata),
    .redirect_valid(1'b0),
    .redirect_pc   (32'h0),
    .instr_valid   (d2_valid),
    .instr         (d2_instr),
    .instr_pc      (d2_pc),
    .instr_ready   (1'b1)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign(d2_misalign)
`endif
  );

`ifndef FETCH_MISALIGN_TRAP_EN
  assign fetch_misalign = 1'b0;
  assign d2_misalign    = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    exp_q.push_back({pc, pc ^ MAGIC});
  endtask

  // Compare the buffer head against the scoreboard; optionally consume it.
  task automatic check_head(input string tag, input bit consume);
    logic [63:0] e;
    if (exp_q.size() != 0) e = consume ? exp_q.pop_front() : exp_q[0];
    else e = 64'hFFFF_FFFF_FFFF_FFFF;
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_pc"}, instr_pc, e[63:32]);
    chk({tag, "_instr"}, instr, e[31:0]);
    if (consume) begin
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
    end
  endtask

  // Directed sequence.
  initial begin
    rst            = 1'b1;
    rst2           = 1'b1;
    imem_ack       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    repeat (3) tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_misalign", 32'(fetch_misalign), 32'd0);

    // Release reset with ack tied high and decode stalled.
    rst = 1'b0;
    chk("first_cycle_req", 32'(imem_req), 32'd0);
    tick();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("addr0", imem_addr, 32'h0);
    chk("valid_before_data", 32'(instr_valid), 32'd0);
    expect_fetch(32'h0);
    tick();
    chk("addr4", imem_addr, 32'h4);
    check_head("head0", 1'b0);
    expect_fetch(32'h4);
    tick();
    chk("full_idle_req", 32'(imem_req), 32'd0);
    tick();
    chk("saturate_req", 32'(imem_req), 32'd0);
    check_head("pop0", 1'b1);
    chk("refill_req", 32'(imem_req), 32'd1);
    chk("addr8", imem_addr, 32'h8);
    expect_fetch(32'h8);
    tick();
    chk("refull_req", 32'(imem_req), 32'd0);

    // Drain the buffer with memory stalled.
    imem_ack = 1'b0;
    check_head("pop4", 1'b1);
    chk("addr12", imem_addr, 32'hC);
    check_head("pop8", 1'b1);
    chk("empty_valid", 32'(instr_valid), 32'd0);
    chk("addr12_held", imem_addr, 32'hC);
    imem_ack = 1'b1;
    expect_fetch(32'hC);
    tick();
    imem_ack = 1'b0;
    chk("addr16", imem_addr, 32'h10);

    // Redirect while the 0x10 request is pending; ack arrives three cycles later.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    exp_q.delete();
    chk("redir_flush", 32'(instr_valid), 32'd0);
    chk("drain_req", 32'(imem_req), 32'd1);
    chk("drain_addr", imem_addr, 32'h10);
    tick();
    chk("drain_hold", imem_addr, 32'h10);
    tick();
    chk("drain_hold2_valid", 32'(instr_valid), 32'd0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("post_drain_addr", imem_addr, 32'h100);
    chk("post_drain_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("wait_valid", 32'(instr_valid), 32'd0);
    imem_ack = 1'b1;
    expect_fetch(32'h100);
    tick();
    imem_ack = 1'b0;
    check_head("head100", 1'b0);
    chk("addr104", imem_addr, 32'h104);

    // Redirect and ack in the same cycle.
    imem_ack       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    exp_q.delete();
    chk("same_cycle_flush", 32'(instr_valid), 32'd0);
    chk("same_cycle_addr", imem_addr, 32'h200);
    expect_fetch(32'h200);
    tick();
    imem_ack = 1'b0;
    chk("addr204", imem_addr, 32'h204);
    check_head("pop200", 1'b1);
    chk("empty_again", 32'(instr_valid), 32'd0);

    // Two redirects while draining: the later target wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    redirect_pc    = 32'h400;
    tick();
    redirect_valid = 1'b0;
    chk("double_drain_addr", imem_addr, 32'h204);
    chk("double_drain_req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("latest_target", imem_addr, 32'h400);

    // Misaligned redirect target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag", 32'(fetch_misalign), 32'd1);
    chk("mis_valid", 32'(instr_valid), 32'd0);
    chk("mis_pend_req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    tick();
    chk("halt_req", 32'(imem_req), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("halt_ignore_req", 32'(imem_req), 32'd0);
    chk("halt_sticky", 32'(fetch_misalign), 32'd1);
    imem_ack = 1'b0;
`else
    chk("mis_drain_addr", imem_addr, 32'h400);
    chk("mis_valid", 32'(instr_valid), 32'd0);
    imem_ack = 1'b1;
    tick();
    chk("masked_addr", imem_addr, 32'h100);
    expect_fetch(32'h100);
    tick();
    imem_ack = 1'b0;
    check_head("masked_head", 1'b0);
`endif

    // Reset overrides a simultaneous ack and redirect.
    rst            = 1'b1;
    imem_ack       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    tick();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    imem_ack       = 1'b0;
    exp_q.delete();
    chk("rst2_req", 32'(imem_req), 32'd0);
    chk("rst2_valid", 32'(instr_valid), 32'd0);
    chk("rst2_misalign", 32'(fetch_misalign), 32'd0);
    tick();
    chk("rst2_addr", imem_addr, 32'h0);
    chk("rst2_req_on", 32'(imem_req), 32'd1);

    // PC wrap from a high reset vector, free running.
    rst2 = 1'b0;
    tick();
    chk("wrap_req", 32'(d2_req), 32'd1);
    chk("wrap_addr0", d2_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap_addr1", d2_addr, 32'hFFFF_FFFC);
    chk("wrap_pc0", d2_pc, 32'hFFFF_FFF8);
    chk("wrap_instr0", d2_instr, 32'hFFFF_FFF8 ^ MAGIC);
    tick();
    chk("wrap_addr2", d2_addr, 32'h0000_0000);
    chk("wrap_pc1", d2_pc, 32'hFFFF_FFFC);
    chk("wrap_valid", 32'(d2_valid), 32'd1);
    chk("wrap_misalign", 32'(d2_misalign), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, SHALL be the instruction buffer depth in entries; only the value 2 is supported.
REQ-003 Clocking and reset are fixed: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 imem_req  out  1  fetch request to instruction memory.
REQ-007 imem_addr  out  32  word-aligned fetch address.
REQ-008 imem_ack  in  1  request accepted; imem_rdata is valid in the same cycle.
REQ-009 imem_rdata  in  32  fetched instruction word.
REQ-010 redirect_valid  in  1  branch, JAL or JALR redirect from execute.
REQ-011 redirect_pc  in  32  redirect target.
REQ-012 instr_valid  out  1  buffer head valid to decode.
REQ-013 instr  out  32  buffer head instruction; decode slices opcode[6:2], funct3 and bit 30 from it.
REQ-014 instr_pc  out  32  PC of the buffer head.
REQ-015 instr_ready  in  1  decode consumes the head.
REQ-016 fetch_misalign  out  1  misaligned redirect flag; present only with FETCH_MISALIGN_TRAP_EN.

Function
REQ-017 The block SHALL implement the states IDLE, REQ and DRAIN, plus HALT when FETCH_MISALIGN_TRAP_EN is defined.
REQ-018 State outputs: imem_req=1 only in REQ and DRAIN; imem_addr = fetch_pc, held stable while imem_req=1 and imem_ack=0.
REQ-019 Transfer rule: a transfer completes on imem_req&&imem_ack.
- In REQ: push {fetch_pc, imem_rdata}; fetch_pc += 4 mod 2^32, so 32'hFFFF_FFFC wraps to 0.
- In DRAIN: discard the data.
REQ-020 IDLE->REQ SHALL occur when the next-cycle buffer count is less than 2.
REQ-021 REQ->IDLE SHALL occur on a push that makes the next-cycle count 2; otherwise REQ holds, giving back-to-back requests at 1 per cycle.
REQ-022 Next-cycle buffer count = count + push - pop.
REQ-023 Pop SHALL be instr_valid&&instr_ready.
REQ-024 instr_valid SHALL equal (count != 0); instr and instr_pc SHALL come from the head entry.
REQ-025 Redirect (redirect_valid=1) at cycle N SHALL:
- flush the buffer, so instr_valid=0 at N+1;
- load fetch_pc <= redirect_pc;
- take priority over pop and push in the same cycle.
REQ-026 Redirect next-state rules:
- in REQ without ack -> DRAIN;
- in REQ with ack -> REQ, ack data discarded;
- in IDLE -> REQ;
- imem_addr = redirect_pc at N+1 when no transfer is outstanding.
REQ-027 In DRAIN:
- a further redirect SHALL overwrite the target and remain in DRAIN;
- on ack -> REQ at the latest target.
REQ-028 Latency: data acked at cycle N SHALL appear with instr_valid=1 at N+1.
REQ-029 Without FETCH_MISALIGN_TRAP_EN, redirect_pc[1:0] SHALL be forced to 0.

Reset
REQ-030 On rst:
- state=IDLE, fetch_pc=RESET_PC, count=0;
- imem_req=0, instr_valid=0, fetch_misalign=0;
- buffer contents are don't-care.
REQ-031 rst SHALL override a pending ack or redirect in the same cycle; an outstanding request SHALL be abandoned.
REQ-032 The first imem_req SHALL assert in the second cycle after rst deasserts.

Configuration
REQ-033 Macro FETCH_MISALIGN_TRAP_EN SHALL control misaligned-redirect trapping.
- Defined: a redirect with redirect_pc[1:0]!=0 SHALL flush the buffer, enter HALT, and set fetch_misalign=1 (sticky until rst); HALT SHALL keep imem_req=0 once any outstanding transfer has been acked, and later redirects SHALL be ignored.
- Undefined: the port is absent and the REQ-029 masking applies.

Structure
REQ-034 Package fetch_pkg SHALL hold:
- the state enum;
- the entry struct {pc[31:0], instr[31:0]};
- constants: BUF_DEPTH, PC_STEP=4, default RESET_PC.
REQ-035 Sub-module fetch_buf (2-entry FIFO, synchronous flush, push/pop same cycle allowed when count=2 with pop) SHALL hold the buffer.

Verification
REQ-036 Reset release, ack tied high -> imem_addr 0,4,8 on consecutive cycles; instr_pc follows one cycle later; state goes IDLE after 2 pushes when instr_ready=0.
REQ-037 instr_ready=0, ack=1 -> count saturates at 2; imem_req=0; pop one -> one new request, addr=8.
REQ-038 Redirect to 32'h100 while a request at 32'h10 is pending (ack delayed 3 cycles) -> DRAIN held; 32'h10 data discarded; next imem_addr=32'h100; instr_valid stays 0 until 32'h100 data arrives.
REQ-039 Redirect and ack in the same cycle -> acked data dropped; imem_addr=redirect_pc next cycle.
REQ-040 RESET_PC=32'hFFFF_FFF8, free run -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-041 Macro defined, redirect_pc=32'h102 -> fetch_misalign=1; instr_valid=0; imem_req stays 0 after drain; macro undefined -> fetch at 32'h100.
